// File: rtl/uart_tx_feeder.sv
// Byte-stream front end for the memory-mapped UART: a 4-deep FIFO feeding a bus-master FSM.
// For each byte the FSM polls status until the transmitter is free, writes Tx data, then triggers.
module uart_tx_feeder #(
  parameter logic [2:0] STATUS_ADDR   = 3'd0,
  parameter logic [2:0] TX_ADDR       = 3'd1,
  parameter logic [2:0] CTRL_ADDR     = 3'd2,
  parameter int         BUSY_BIT      = 0,
  parameter logic [7:0] CTRL_GO       = 8'h01,
  parameter int         STROBE_CYCLES = 2,
  parameter int         POLL_LIMIT    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        cs,
  output logic        rd,
  output logic        wr,
  output logic [2:0]  addr,
  output logic [7:0]  in_data,
  input  logic [7:0]  out_data,
  output logic        busy,
  output logic [15:0] sent_count,
  output logic        timeout
);

  localparam int SW = (STROBE_CYCLES < 2) ? 1 : $clog2(STROBE_CYCLES + 1);
  localparam int PW = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_STATUS, S_CHECK, S_WR_DATA, S_WR_CTRL, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      fifo_q [4];
  logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  logic            push, pop;
  logic [7:0]      byte_q, byte_d;
  logic            stat_busy_q, stat_busy_d;
  logic [SW-1:0]   stb_q, stb_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [15:0]     sent_q, sent_d;
  logic            timeout_q, timeout_d;
  logic            cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic [2:0]      addr_q, addr_d;
  logic [7:0]      in_data_q, in_data_d;
  logic            busy_q, busy_d, in_ready_q, in_ready_d;
  logic            last_stb;

  // Only the busy flag of the status byte matters; the rest is read and discarded.
  logic            status_unused;
  assign status_unused = ^out_data;

  assign push     = in_valid && in_ready_q;
  assign last_stb = (stb_q == SW'(STROBE_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    byte_d      = byte_q;
    stat_busy_d = stat_busy_q;
    stb_d       = stb_q;
    poll_d      = poll_q;
    sent_d      = sent_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          byte_d  = fifo_q[rd_ptr_q];
          poll_d  = '0;
          stb_d   = '0;
          state_d = S_RD_STATUS;
        end
      end
      S_RD_STATUS: begin
        if (last_stb) begin
          stat_busy_d = out_data[BUSY_BIT];
          state_d     = S_CHECK;
        end else begin
          stb_d = stb_q + 1'b1;
        end
      end
      S_CHECK: begin
        stb_d = '0;
        if (!stat_busy_q) begin
          state_d = S_WR_DATA;
        end else if (poll_q == PW'(POLL_LIMIT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_GAP;
        end else begin
          poll_d  = poll_q + 1'b1;
          state_d = S_RD_STATUS;
        end
      end
      S_WR_DATA: begin
        if (last_stb) begin
          stb_d   = '0;
          state_d = S_WR_CTRL;
        end else begin
          stb_d = stb_q + 1'b1;
        end
      end
      S_WR_CTRL: begin
        if (last_stb) begin
          sent_d  = sent_q + 16'd1;
          state_d = S_GAP;
        end else begin
          stb_d = stb_q + 1'b1;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    cs_d      = 1'b1;
    rd_d      = 1'b1;
    wr_d      = 1'b1;
    addr_d    = addr_q;
    in_data_d = in_data_q;
    case (state_d)
      S_RD_STATUS:          begin cs_d = 1'b0; rd_d = 1'b0; end
      S_WR_DATA, S_WR_CTRL: begin cs_d = 1'b0; wr_d = 1'b0; end
      default: ;
    endcase
    if (state_d != state_q) begin
      case (state_d)
        S_RD_STATUS: addr_d = STATUS_ADDR;
        S_WR_DATA:   begin addr_d = TX_ADDR;   in_data_d = byte_q;  end
        S_WR_CTRL:   begin addr_d = CTRL_ADDR; in_data_d = CTRL_GO; end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {1'b0, push};
    rd_ptr_d   = rd_ptr_q + {1'b0, pop};
    count_d    = count_q + {2'b00, push} - {2'b00, pop};
    in_ready_d = (count_d != 3'd4);
    busy_d     = (count_d != 3'd0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= in_byte;
  end

  always_ff @(posedge clock) begin
    byte_q      <= byte_d;
    stat_busy_q <= stat_busy_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stb_q      <= '0;
      poll_q     <= '0;
      sent_q     <= '0;
      timeout_q  <= 1'b0;
      cs_q       <= 1'b1;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      addr_q     <= '0;
      in_data_q  <= '0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stb_q      <= stb_d;
      poll_q     <= poll_d;
      sent_q     <= sent_d;
      timeout_q  <= timeout_d;
      cs_q       <= cs_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      in_data_q  <= in_data_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign cs         = cs_q;
  assign rd         = rd_q;
  assign wr         = wr_q;
  assign addr       = addr_q;
  assign in_data    = in_data_q;
  assign busy       = busy_q;
  assign sent_count = sent_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a UART status responder plus a bus monitor, checked against
// a per-byte transaction model (reads = min(busy+1, limit), then data and trigger writes).
module tb_uart_tx_feeder;
  localparam int S  = 2;
  localparam int PL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready, cs, rd, wr, busy, timeout;
  logic [2:0]  addr;
  logic [7:0]  in_data;
  logic [7:0]  out_data = 8'h00;
  logic [15:0] sent_count;

  uart_tx_feeder #(.STROBE_CYCLES(S), .POLL_LIMIT(PL)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .in_data(in_data), .out_data(out_data), .busy(busy),
    .sent_count(sent_count), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct { logic is_rd; logic [2:0] a; logic [7:0] d; } ev_t;
  typedef struct { logic cs, rd, wr; logic [2:0] a; logic [7:0] d; logic bsy; logic [15:0] sent; } cyc_t;
  typedef struct { logic [7:0] b; int k; int exp_reads; logic exp_wrote; logic exp_to; int exp_sent; } txn_t;

  int total = 0;
  int bad   = 0;
  ev_t log_q[$];
  int  busy_plan[$];
  logic [7:0] exp_bytes[$];
  int  exp_busy[$];
  int  cur_busy = 0, reads_this = 0, proto_err = 0, stalls = 0;
  logic [15:0] exp_sent = 16'd0;
  logic exp_to = 1'b0;
  logic prev_cs = 1'b1, prev_rd = 1'b1;
  logic [2:0] prev_addr = 3'd0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus monitor and UART status responder.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      prev_cs = 1'b1;
      reads_this = 0;
    end else begin
      if (!rd && !wr) proto_err++;
      if (cs != (rd & wr)) proto_err++;
      if (!cs) begin
        if (prev_cs || addr != prev_addr || rd != prev_rd) begin
          if (!rd) begin
            log_q.push_back('{1'b1, addr, 8'h00});
            if (reads_this == 0) cur_busy = (busy_plan.size() > 0) ? busy_plan.pop_front() : 0;
            out_data = (reads_this < cur_busy) ? 8'h01 : 8'h00;
            reads_this++;
            if (out_data == 8'h00 || reads_this == PL) reads_this = 0;
          end else begin
            log_q.push_back('{1'b0, addr, in_data});
          end
        end else if (in_data != prev_data) begin
          proto_err++;
        end
      end
      prev_cs = cs; prev_rd = rd; prev_addr = addr; prev_data = in_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b);
    int g = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && g < 1000) begin
      stalls++;
      @(negedge clock);
      g++;
    end
    @(negedge clock);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    repeat (3) @(negedge clock);
    while (busy && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk({nm, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_sent = 16'd0;
    exp_to = 1'b0;
    @(negedge clock);
  endtask

  // Expected bus transactions are derived from the byte list and each byte's busy-poll count.
  task automatic check_log(input string nm);
    ev_t e[$];
    int nr, mi;
    foreach (exp_bytes[i]) begin
      nr = (exp_busy[i] + 1 < PL) ? exp_busy[i] + 1 : PL;
      repeat (nr) e.push_back('{1'b1, 3'd0, 8'h00});
      if (exp_busy[i] < PL) begin
        e.push_back('{1'b0, 3'd1, exp_bytes[i]});
        e.push_back('{1'b0, 3'd2, 8'h01});
        exp_sent = exp_sent + 16'd1;
      end else begin
        exp_to = 1'b1;
      end
    end
    chk({nm, " event count"}, log_q.size(), e.size());
    mi = -1;
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      if (mi < 0 && (log_q[i].is_rd !== e[i].is_rd || log_q[i].a !== e[i].a || log_q[i].d !== e[i].d)) mi = i;
    total++;
    if (mi >= 0) begin
      bad++;
      $display("FAIL %s event %0d: got rd=%0b a=%0d d=%02h expected rd=%0b a=%0d d=%02h", nm, mi,
               log_q[mi].is_rd, log_q[mi].a, log_q[mi].d, e[mi].is_rd, e[mi].a, e[mi].d);
    end
    exp_bytes.delete();
    exp_busy.delete();
  endtask

  cyc_t cyc[10];
  txn_t tv[4];

  initial begin
    int nlog, nrd, g;
    logic wrote;
    logic [7:0] rb;
    int rk;

    cyc[0] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 16'd0};
    cyc[1] = '{1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 16'd0};
    cyc[2] = '{1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 16'd0};
    cyc[3] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 16'd0};
    cyc[4] = '{1'b0, 1'b1, 1'b0, 3'd1, 8'hA5, 1'b1, 16'd0};
    cyc[5] = '{1'b0, 1'b1, 1'b0, 3'd1, 8'hA5, 1'b1, 16'd0};
    cyc[6] = '{1'b0, 1'b1, 1'b0, 3'd2, 8'h01, 1'b1, 16'd0};
    cyc[7] = '{1'b0, 1'b1, 1'b0, 3'd2, 8'h01, 1'b1, 16'd0};
    cyc[8] = '{1'b1, 1'b1, 1'b1, 3'd2, 8'h01, 1'b1, 16'd1};
    cyc[9] = '{1'b1, 1'b1, 1'b1, 3'd2, 8'h01, 1'b0, 16'd1};
    tv[0] = '{8'h5A, 3, 4, 1'b1, 1'b0, 2};
    tv[1] = '{8'hC3, 1, 2, 1'b1, 1'b0, 3};
    tv[2] = '{8'h7E, 9, 4, 1'b0, 1'b1, 3};
    tv[3] = '{8'h3C, 0, 1, 1'b1, 1'b1, 4};

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst cs", {31'd0, cs}, 32'd1);
    chk("rst rd", {31'd0, rd}, 32'd1);
    chk("rst wr", {31'd0, wr}, 32'd1);
    chk("rst addr", {29'd0, addr}, 32'd0);
    chk("rst in_data", {24'd0, in_data}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst sent_count", {16'd0, sent_count}, 32'd0);
    chk("rst timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Cycle-exact single byte A5 with a free UART
    in_valid = 1'b1;
    in_byte  = 8'hA5;
    @(negedge clock);
    in_valid = 1'b0;
    for (int r = 0; r < 10; r++) begin
      chk($sformatf("cycle %0d {cs,rd,wr,addr,data,busy,sent}", r),
          {1'b0, cs, rd, wr, addr, in_data, busy, sent_count},
          {1'b0, cyc[r].cs, cyc[r].rd, cyc[r].wr, cyc[r].a, cyc[r].d, cyc[r].bsy, cyc[r].sent});
      @(negedge clock);
    end
    wait_idle("single");
    exp_bytes = '{8'hA5};
    exp_busy  = '{0};
    check_log("single");

    // Per-byte busy-poll table
    for (int i = 0; i < 4; i++) begin
      log_q.delete();
      busy_plan = '{tv[i].k};
      push(tv[i].b);
      in_valid = 1'b0;
      wait_idle($sformatf("txn %0d", i));
      nrd = 0;
      wrote = 1'b0;
      foreach (log_q[j]) begin
        if (log_q[j].is_rd) nrd++;
        else if (log_q[j].a == 3'd1 && log_q[j].d == tv[i].b) wrote = 1'b1;
      end
      chk($sformatf("txn %0d status reads", i), nrd, tv[i].exp_reads);
      chk($sformatf("txn %0d data written", i), {31'd0, wrote}, {31'd0, tv[i].exp_wrote});
      chk($sformatf("txn %0d timeout", i), {31'd0, timeout}, {31'd0, tv[i].exp_to});
      chk($sformatf("txn %0d sent_count", i), {16'd0, sent_count}, tv[i].exp_sent);
    end

    // Stuck status with the next byte already queued
    do_reset();
    log_q.delete();
    busy_plan = '{9, 0};
    exp_bytes = '{8'h7E, 8'h3C};
    exp_busy  = '{9, 0};
    push(8'h7E);
    push(8'h3C);
    in_valid = 1'b0;
    wait_idle("stuck");
    check_log("stuck");
    chk("stuck timeout", {31'd0, timeout}, 32'd1);
    chk("stuck sent_count", {16'd0, sent_count}, {16'd0, exp_sent});

    // Burst of six with in_valid held high
    log_q.delete();
    stalls = 0;
    for (int i = 1; i <= 6; i++) begin
      busy_plan.push_back(0);
      exp_bytes.push_back(i[7:0]);
      exp_busy.push_back(0);
      push(i[7:0]);
    end
    in_valid = 1'b0;
    wait_idle("burst");
    chk("burst saw in_ready low", {31'd0, stalls != 0}, 32'd1);
    check_log("burst");
    chk("burst sent_count", {16'd0, sent_count}, {16'd0, exp_sent});

    // Randomized bytes, busy counts and gaps
    do_reset();
    log_q.delete();
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      rk = $urandom_range(0, 5);
      busy_plan.push_back(rk);
      exp_bytes.push_back(rb);
      exp_busy.push_back(rk);
      push(rb);
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 12)) @(negedge clock);
      end
    end
    in_valid = 1'b0;
    wait_idle("random");
    check_log("random");
    chk("random sent_count", {16'd0, sent_count}, {16'd0, exp_sent});
    chk("random timeout", {31'd0, timeout}, {31'd0, exp_to});
    chk("protocol violations", proto_err, 0);

    // Reset during the data write with two bytes queued
    log_q.delete();
    busy_plan = '{0, 0, 0};
    push(8'h11);
    push(8'h22);
    push(8'h33);
    in_valid = 1'b0;
    g = 0;
    while (!(!wr && addr == 3'd1) && g < 200) begin
      @(negedge clock);
      g++;
    end
    chk("reached data write", {31'd0, !wr && addr == 3'd1}, 32'd1);
    nlog = log_q.size();
    reset = 1'b1;
    @(negedge clock);
    chk("midrst strobes {cs,rd,wr}", {29'd0, cs, rd, wr}, 32'd7);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst sent_count", {16'd0, sent_count}, 32'd0);
    reset = 1'b0;
    exp_sent = 16'd0;
    repeat (30) @(negedge clock);
    chk("midrst no bus activity", log_q.size(), nlog);
    chk("midrst stays idle", {31'd0, busy}, 32'd0);
    busy_plan.delete();

    // sent_count wrap
    log_q.delete();
    dut.sent_q = 16'hFFFF;
    @(negedge clock);
    push(8'h5C);
    in_valid = 1'b0;
    wait_idle("wrap");
    chk("wrap sent_count", {16'd0, sent_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
